mem_bus_arbiter: RTL and testbench

Arbitrates one shared downstream memory port between the fetch stage's instruction requester (I) and the memory stage's data requester (D). The I port is read-only; the D port handles loads and stores. Only one transaction is outstanding at a time. The block registers each granted request, drives it downstream until accepted, and routes the handshake responses back to the owning requester only. D has priority, bounded by an anti-starvation counter so fetch always makes progress. It sits between the pipeline's ibus/dbus request structs and the single core-side memory bus.

---
 rtl/mem_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter that shares one downstream memory port between instruction fetch (I) and data (D).
// D wins contested grants until it has won STARVE_LIMIT in a row while I waited; then I is served.
module mem_bus_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [63:0] i_addr,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   output logic [63:0] i_data,
   input  logic        d_valid,
   input  logic [63:0] d_addr,
   input  logic [2:0]  d_size,
   input  logic [7:0]  d_strobe,
   input  logic [63:0] d_wdata,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic [63:0] d_data,
   output logic        m_valid,
   output logic [63:0] m_addr,
   output logic [2:0]  m_size,
   output logic [7:0]  m_strobe,
   output logic [63:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [63:0] m_data
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic          r_owner;
   logic [CW-1:0] r_starve_cnt;
   logic [63:0]   r_m_addr;
   logic [2:0]    r_m_size;
   logic [7:0]    r_m_strobe;
   logic [63:0]   r_m_wdata;

   logic          w_grant_i;
   logic          w_grant_d;
   logic          w_starved;
   logic          w_addr_ack;
   logic          w_data_ack;

   assign w_starved = (r_starve_cnt == CW'(STARVE_LIMIT));

   always_comb begin
      w_state_next = r_state;
      w_grant_i    = 1'b0;
      w_grant_d    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_valid && (!d_valid || w_starved)) begin
               w_grant_i = 1'b1;
            end else if (d_valid) begin
               w_grant_d = 1'b1;
            end
            if (w_grant_i || w_grant_d) begin
               w_state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (m_addr_ok) begin
               w_state_next = m_data_ok ? ST_IDLE : ST_RESP;
            end
         end
         ST_RESP: begin
            if (m_data_ok) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // A completion in the acceptance cycle is honoured exactly like one in RESP.
   assign w_addr_ack = (r_state == ST_REQ) && m_addr_ok;
   assign w_data_ack = ((r_state == ST_REQ) && m_addr_ok && m_data_ok) ||
                       ((r_state == ST_RESP) && m_data_ok);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWN_I;
         r_starve_cnt <= '0;
         r_m_addr     <= '0;
         r_m_size     <= '0;
         r_m_strobe   <= '0;
         r_m_wdata    <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_grant_i) begin
            r_owner    <= OWN_I;
            r_m_addr   <= i_addr;
            r_m_size   <= 3'b011;
            r_m_strobe <= '0;
            r_m_wdata  <= '0;
         end else if (w_grant_d) begin
            r_owner    <= OWN_D;
            r_m_addr   <= d_addr;
            r_m_size   <= d_size;
            r_m_strobe <= d_strobe;
            r_m_wdata  <= d_wdata;
         end
         // Counts D wins only while fetch is actually waiting.
         if (r_state == ST_IDLE) begin
            if (w_grant_d && i_valid) begin
               if (!w_starved) begin
                  r_starve_cnt <= r_starve_cnt + CW'(1);
               end
            end else if (w_grant_i || !i_valid) begin
               r_starve_cnt <= '0;
            end
         end
      end
   end

   assign m_valid   = (r_state == ST_REQ);
   assign m_addr    = r_m_addr;
   assign m_size    = r_m_size;
   assign m_strobe  = r_m_strobe;
   assign m_wdata   = r_m_wdata;

   assign i_addr_ok = w_addr_ack && (r_owner == OWN_I);
   assign i_data_ok = w_data_ack && (r_owner == OWN_I);
   assign d_addr_ok = w_addr_ack && (r_owner == OWN_D);
   assign d_data_ok = w_data_ack && (r_owner == OWN_D);
   assign i_data    = m_data;
   assign d_data    = m_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1 ns after posedge, outputs are sampled on negedge.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic [63:0] i_addr;
   logic        i_addr_ok;
   logic        i_data_ok;
   logic [63:0] i_data;
   logic        d_valid;
   logic [63:0] d_addr;
   logic [2:0]  d_size;
   logic [7:0]  d_strobe;
   logic [63:0] d_wdata;
   logic        d_addr_ok;
   logic        d_data_ok;
   logic [63:0] d_data;
   logic        m_valid;
   logic [63:0] m_addr;
   logic [2:0]  m_size;
   logic [7:0]  m_strobe;
   logic [63:0] m_wdata;
   logic        m_addr_ok;
   logic        m_data_ok;
   logic [63:0] m_data;

   int n_checks = 0;
   int n_errors = 0;

   mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (i_valid),
      .i_addr    (i_addr),
      .i_addr_ok (i_addr_ok),
      .i_data_ok (i_data_ok),
      .i_data    (i_data),
      .d_valid   (d_valid),
      .d_addr    (d_addr),
      .d_size    (d_size),
      .d_strobe  (d_strobe),
      .d_wdata   (d_wdata),
      .d_addr_ok (d_addr_ok),
      .d_data_ok (d_data_ok),
      .d_data    (d_data),
      .m_valid   (m_valid),
      .m_addr    (m_addr),
      .m_size    (m_size),
      .m_strobe  (m_strobe),
      .m_wdata   (m_wdata),
      .m_addr_ok (m_addr_ok),
      .m_data_ok (m_data_ok),
      .m_data    (m_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic no_acks(input string tag);
      chk({tag, "_iaok"}, 64'(i_addr_ok), 64'd0);
      chk({tag, "_idok"}, 64'(i_data_ok), 64'd0);
      chk({tag, "_daok"}, 64'(d_addr_ok), 64'd0);
      chk({tag, "_ddok"}, 64'(d_data_ok), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] exp_d;
      int         n_daok;
      int         n_ddok;
      int         n_iaok;
      int         n_idok;

      rst = 1'b0;
      i_valid = 1'b0; i_addr = '0;
      d_valid = 1'b0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_data = '0;

      // reset state
      @(negedge clk);
      chk("rst_mvalid", 64'(m_valid), 64'd0);
      chk("rst_maddr", m_addr, 64'd0);
      no_acks("rst");
      tick();
      rst = 1'b1;
      tick();

      // single fetch
      i_valid = 1'b1; i_addr = 64'h8000_0000;
      @(negedge clk);
      chk("fetch_mvalid_pre", 64'(m_valid), 64'd0);
      tick();
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_data = 64'h13;
      @(negedge clk);
      chk("fetch_mvalid", 64'(m_valid), 64'd1);
      chk("fetch_maddr", m_addr, 64'h8000_0000);
      chk("fetch_mstrobe", 64'(m_strobe), 64'd0);
      chk("fetch_msize", 64'(m_size), 64'd3);
      chk("fetch_iaok", 64'(i_addr_ok), 64'd1);
      chk("fetch_idok", 64'(i_data_ok), 64'd1);
      chk("fetch_idata", i_data, 64'h13);
      chk("fetch_daok", 64'(d_addr_ok), 64'd0);
      chk("fetch_ddok", 64'(d_data_ok), 64'd0);
      tick();
      i_valid = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
      @(negedge clk);
      chk("fetch_mvalid_post", 64'(m_valid), 64'd0);
      $display("txn single_fetch addr=0x80000000 data=0x13");
      tick();

      // contested store: D first, then I after a bubble
      i_valid = 1'b1; i_addr = 64'h2000;
      d_valid = 1'b1; d_addr = 64'h100; d_size = 3'd3; d_strobe = 8'hFF; d_wdata = 64'h114514;
      tick();
      m_addr_ok = 1'b1;
      @(negedge clk);
      chk("cont_maddr", m_addr, 64'h100);
      chk("cont_mstrobe", 64'(m_strobe), 64'hFF);
      chk("cont_mwdata", m_wdata, 64'h114514);
      chk("cont_daok", 64'(d_addr_ok), 64'd1);
      chk("cont_iaok", 64'(i_addr_ok), 64'd0);
      tick();
      m_addr_ok = 1'b0; m_data_ok = 1'b1; m_data = 64'hAA;
      @(negedge clk);
      chk("cont_mvalid_resp", 64'(m_valid), 64'd0);
      chk("cont_ddok", 64'(d_data_ok), 64'd1);
      chk("cont_ddata", d_data, 64'hAA);
      chk("cont_idok", 64'(i_data_ok), 64'd0);
      tick();
      d_valid = 1'b0; m_data_ok = 1'b0;
      @(negedge clk);
      chk("cont_bubble", 64'(m_valid), 64'd0);
      tick();
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_data = 64'h55;
      @(negedge clk);
      chk("cont_i_mvalid", 64'(m_valid), 64'd1);
      chk("cont_i_maddr", m_addr, 64'h2000);
      chk("cont_i_mstrobe", 64'(m_strobe), 64'd0);
      chk("cont_i_idok", 64'(i_data_ok), 64'd1);
      tick();
      m_addr_ok = 1'b0; m_data_ok = 1'b0;
      $display("txn contested_store d_addr=0x100 then i_addr=0x2000");

      // starvation: expected grant order D,D,D,D,I,D (bit k = 1 means D)
      exp_d = 6'b101111;
      d_valid = 1'b1; d_addr = 64'h100; d_strobe = 8'h00; d_size = 3'd3;
      for (int k = 0; k < 6; k++) begin
         tick();
         m_addr_ok = 1'b1; m_data_ok = 1'b1; m_data = 64'(k);
         @(negedge clk);
         chk("starve_maddr", m_addr, exp_d[k] ? 64'h100 : 64'h2000);
         chk("starve_ack", exp_d[k] ? 64'(d_data_ok) : 64'(i_data_ok), 64'd1);
         chk("starve_nack", exp_d[k] ? 64'(i_data_ok) : 64'(d_data_ok), 64'd0);
         if (k == 3) chk("starve_cnt_full", 64'(dut.r_starve_cnt), 64'd4);
         if (k == 4) chk("starve_cnt_clr", 64'(dut.r_starve_cnt), 64'd0);
         tick();
         m_addr_ok = 1'b0; m_data_ok = 1'b0;
         $display("txn starve grant=%0d owner=%s", k, exp_d[k] ? "D" : "I");
      end
      i_valid = 1'b0; d_valid = 1'b0;
      tick();

      // slow memory: 4 REQ cycles, 2 RESP cycles
      d_valid = 1'b1; d_addr = 64'h300; d_size = 3'd2; d_strobe = 8'h00; d_wdata = 64'h0;
      n_daok = 0; n_ddok = 0; n_iaok = 0; n_idok = 0;
      tick();
      for (int k = 0; k < 4; k++) begin
         m_addr_ok = (k == 3);
         @(negedge clk);
         chk("slow_mvalid", 64'(m_valid), 64'd1);
         chk("slow_maddr", m_addr, 64'h300);
         chk("slow_msize", 64'(m_size), 64'd2);
         n_daok += int'(d_addr_ok); n_ddok += int'(d_data_ok);
         n_iaok += int'(i_addr_ok); n_idok += int'(i_data_ok);
         tick();
      end
      m_addr_ok = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_data_ok = (k == 1); m_data = 64'h77;
         @(negedge clk);
         chk("slow_resp_mvalid", 64'(m_valid), 64'd0);
         n_daok += int'(d_addr_ok); n_ddok += int'(d_data_ok);
         n_iaok += int'(i_addr_ok); n_idok += int'(i_data_ok);
         if (k == 1) chk("slow_ddata", d_data, 64'h77);
         tick();
      end
      d_valid = 1'b0; m_data_ok = 1'b0;
      chk("slow_n_daok", 64'(n_daok), 64'd1);
      chk("slow_n_ddok", 64'(n_ddok), 64'd1);
      chk("slow_n_iaok", 64'(n_iaok), 64'd0);
      chk("slow_n_idok", 64'(n_idok), 64'd0);
      $display("txn slow_memory d_addr=0x300 daok=%0d ddok=%0d", n_daok, n_ddok);
      tick();

      // reset while in RESP
      i_valid = 1'b1; i_addr = 64'h4000;
      tick();
      m_addr_ok = 1'b1;
      tick();
      m_addr_ok = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("rstm_mvalid", 64'(m_valid), 64'd0);
      chk("rstm_maddr", m_addr, 64'd0);
      chk("rstm_msize", 64'(m_size), 64'd0);
      no_acks("rstm");
      tick();
      rst = 1'b1; i_valid = 1'b0; m_data_ok = 1'b1; m_data = 64'h99;
      @(negedge clk);
      no_acks("rstm_late");
      tick();
      m_data_ok = 1'b0;
      i_valid = 1'b1; i_addr = 64'h5000;
      tick();
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_data = 64'h66;
      @(negedge clk);
      chk("rstm_regrant_maddr", m_addr, 64'h5000);
      chk("rstm_regrant_idok", 64'(i_data_ok), 64'd1);
      tick();
      i_valid = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
      $display("txn reset_mid_resp then fetch addr=0x5000");
      tick();

      // D drops valid and changes fields before acceptance
      d_valid = 1'b1; d_addr = 64'h600; d_size = 3'd2; d_strobe = 8'h0F; d_wdata = 64'h77;
      tick();
      d_valid = 1'b0; d_addr = 64'hDEAD; d_strobe = 8'h00; d_wdata = 64'h0;
      @(negedge clk);
      chk("drop_mvalid", 64'(m_valid), 64'd1);
      chk("drop_maddr", m_addr, 64'h600);
      chk("drop_mstrobe", 64'(m_strobe), 64'h0F);
      chk("drop_mwdata", m_wdata, 64'h77);
      tick();
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_data = 64'h1;
      @(negedge clk);
      chk("drop_maddr2", m_addr, 64'h600);
      chk("drop_daok", 64'(d_addr_ok), 64'd1);
      chk("drop_ddok", 64'(d_data_ok), 64'd1);
      tick();
      m_addr_ok = 1'b0; m_data_ok = 1'b0;
      @(negedge clk);
      chk("drop_idle_mvalid", 64'(m_valid), 64'd0);
      no_acks("drop_idle");
      $display("txn dropped_valid d_addr=0x600");
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
